// File: rtl/mlp_classifier_seq_if.sv
// rtl/mlp_classifier_seq_if.sv - start/busy/done handshake and result bundle for the MLP classifier
interface mlp_classifier_seq_if #(
    parameter int ACC_W = 24,
    parameter int LBL_W = 8
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [LBL_W-1:0]        label;
    logic signed [ACC_W-1:0] score;

    modport master (output start, input busy, done, label, score);
    modport slave  (input start, output busy, done, label, score);
endinterface

// File: rtl/mlp_classifier_seq.sv
// rtl/mlp_classifier_seq.sv - sequential two-layer MLP classifier with one shared MAC
module mlp_classifier_seq #(
    parameter int N_IN  = 62,
    parameter int N_HID = 20,
    parameter int N_OUT = 10,
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int FRAC  = 7,
    parameter int LBL_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mlp_classifier_seq_if.slave       ctl,
    input  logic [N_IN*DW-1:0]        test_data,
    input  logic [N_HID*N_IN*DW-1:0]  wh,
    input  logic [N_HID*DW-1:0]       bh,
    input  logic [N_OUT*N_HID*DW-1:0] wo,
    input  logic [N_OUT*DW-1:0]       bo
);
    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // Every accumulated term (product or shifted bias) fits in TERM_W signed bits;
    // summing at most MAX_TERMS of them needs clog2(MAX_TERMS) extra bits.
    localparam int MAX_TERMS = ((N_IN > N_HID) ? N_IN : N_HID) + 1;
    localparam int TERM_W    = (DW + FRAC > 2 * DW) ? DW + FRAC : 2 * DW;
    localparam int NEED_W    = TERM_W + $clog2(MAX_TERMS);

    if (ACC_W < NEED_W) begin : g_acc_w_check
        $error("mlp_classifier_seq: ACC_W too small for the configured layer sizes");
    end

    localparam logic signed [ACC_W-1:0] H_MAX = ACC_W'((1 << (DW - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HBIAS, S_HMAC, S_HACT, S_OBIAS, S_OMAC, S_OCMP, S_FIN
    } state_t;

    state_t                  state, state_nxt;
    logic [N_IN*DW-1:0]      x_q;
    logic signed [DW-1:0]    h_q [N_HID];
    logic signed [ACC_W-1:0] acc, best, relu_sh;
    logic [IW-1:0]           i_cnt;
    logic [JW-1:0]           j_cnt;
    logic [KW-1:0]           k_cnt, best_idx;
    logic signed [DW-1:0]    op_a, op_b, bias, h_new;
    logic signed [2*DW-1:0]  prod;

    assign ctl.busy = (state != S_IDLE);
    assign prod     = (2 * DW)'(op_a) * (2 * DW)'(op_b);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Phase sequencing: hidden neurons first, then output neurons, then publish
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ctl.start) state_nxt = S_HBIAS;
            S_HBIAS: state_nxt = S_HMAC;
            S_HMAC:  if (i_cnt == IW'(N_IN - 1)) state_nxt = S_HACT;
            S_HACT:  state_nxt = (j_cnt == JW'(N_HID - 1)) ? S_OBIAS : S_HBIAS;
            S_OBIAS: state_nxt = S_OMAC;
            S_OMAC:  if (j_cnt == JW'(N_HID - 1)) state_nxt = S_OCMP;
            S_OCMP:  state_nxt = (k_cnt == KW'(N_OUT - 1)) ? S_FIN : S_OBIAS;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shared MAC operand selection: features x hidden weights, or hidden x output weights
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state == S_HMAC) begin
            op_a = x_q[int'(i_cnt) * DW +: DW];
            op_b = wh[(int'(j_cnt) * N_IN + int'(i_cnt)) * DW +: DW];
        end else begin
            op_a = h_q[j_cnt];
            op_b = wo[(int'(k_cnt) * N_HID + int'(j_cnt)) * DW +: DW];
        end
        bias = (state == S_HBIAS) ? bh[int'(j_cnt) * DW +: DW] : bo[int'(k_cnt) * DW +: DW];
    end

    // ReLU, rescale, and saturate to the positive range of a DW-bit signed value
    always_comb begin
        relu_sh = acc >>> FRAC;
        if (acc[ACC_W-1])       h_new = '0;
        else if (relu_sh > H_MAX) h_new = {1'b0, {(DW - 1){1'b1}}};
        else                    h_new = relu_sh[DW-1:0];
    end

    // Datapath: capture, accumulate, activate, track the best output, publish
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q       <= '0;
            acc       <= '0;
            best      <= '0;
            best_idx  <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            ctl.done  <= 1'b0;
            ctl.label <= '0;
            ctl.score <= '0;
            for (int n = 0; n < N_HID; n++) h_q[n] <= '0;
        end else begin
            ctl.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctl.start) begin
                        x_q   <= test_data;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        k_cnt <= '0;
                    end
                end
                S_HBIAS: begin
                    acc   <= ACC_W'(bias) <<< FRAC;
                    i_cnt <= '0;
                end
                S_HMAC: begin
                    acc   <= acc + ACC_W'(prod);
                    i_cnt <= i_cnt + 1'b1;
                end
                S_HACT: begin
                    h_q[j_cnt] <= h_new;
                    if (j_cnt == JW'(N_HID - 1)) begin
                        j_cnt <= '0;
                        k_cnt <= '0;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                S_OBIAS: begin
                    acc   <= ACC_W'(bias) <<< FRAC;
                    j_cnt <= '0;
                end
                S_OMAC: begin
                    acc   <= acc + ACC_W'(prod);
                    j_cnt <= j_cnt + 1'b1;
                end
                S_OCMP: begin
                    // Strict compare keeps the lower index on ties
                    if (k_cnt == '0 || acc > best) begin
                        best     <= acc;
                        best_idx <= k_cnt;
                    end
                    k_cnt <= k_cnt + 1'b1;
                end
                S_FIN: begin
                    ctl.label <= LBL_W'(best_idx);
                    ctl.score <= best;
                    ctl.done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_classifier_seq.sv
// tb/tb_mlp_classifier_seq.sv - self-checking bench for mlp_classifier_seq (small and default configs)
module tb_mlp_classifier_seq;
    localparam int BN_IN  = 62;
    localparam int BN_HID = 20;
    localparam int BN_OUT = 10;
    localparam int BFRAC  = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] s_x, s_bh, s_bo;
    logic [31:0] s_wh, s_wo;
    logic [BN_IN*8-1:0]        b_x;
    logic [BN_HID*BN_IN*8-1:0] b_wh;
    logic [BN_HID*8-1:0]       b_bh;
    logic [BN_OUT*BN_HID*8-1:0] b_wo;
    logic [BN_OUT*8-1:0]       b_bo;

    mlp_classifier_seq_if #(.ACC_W(24), .LBL_W(8)) s_if ();
    mlp_classifier_seq_if #(.ACC_W(24), .LBL_W(8)) b_if ();

    mlp_classifier_seq #(
        .N_IN(2), .N_HID(2), .N_OUT(2), .DW(8), .ACC_W(24), .FRAC(0), .LBL_W(8)
    ) u_small (
        .clk(clk), .rst(rst), .ctl(s_if),
        .test_data(s_x), .wh(s_wh), .bh(s_bh), .wo(s_wo), .bo(s_bo)
    );

    mlp_classifier_seq u_big (
        .clk(clk), .rst(rst), .ctl(b_if),
        .test_data(b_x), .wh(b_wh), .bh(b_bh), .wo(b_wo), .bo(b_bo)
    );

    typedef struct {
        logic [15:0] x;
        logic [31:0] wh;
        logic [15:0] bh;
        logic [31:0] wo;
        logic [15:0] bo;
        int          exp_label;
        int          exp_score;
    } vec_t;

    vec_t vecs[7];

    int rx[BN_IN];
    int rwh[BN_HID*BN_IN];
    int rbh[BN_HID];
    int rwo[BN_OUT*BN_HID];
    int rbo[BN_OUT];

    function automatic logic [15:0] p2(input int a0, input int a1);
        return {8'(a1), 8'(a0)};
    endfunction

    function automatic logic [31:0] p4(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit get_done(input bit big);
        return big ? b_if.done : s_if.done;
    endfunction

    function automatic bit get_busy(input bit big);
        return big ? b_if.busy : s_if.busy;
    endfunction

    // Called #1 after a clock edge; pulses start, measures edges until done.
    task automatic run_and_wait(input bit big, input int limit, output int lat);
        if (big) b_if.start = 1'b1; else s_if.start = 1'b1;
        @(posedge clk); #1;
        if (big) b_if.start = 1'b0; else s_if.start = 1'b0;
        chk("busy_after_start", longint'(get_busy(big)), 1);
        lat = 0;
        while (!get_done(big) && lat <= limit) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_low_at_done", longint'(get_busy(big)), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", longint'(get_done(big)), 0);
    endtask

    task automatic run_small(input int n);
        int lat;
        s_x = vecs[n].x; s_wh = vecs[n].wh; s_bh = vecs[n].bh;
        s_wo = vecs[n].wo; s_bo = vecs[n].bo;
        run_and_wait(1'b0, 40, lat);
        chk($sformatf("small_latency[%0d]", n), lat, 17);
        chk($sformatf("small_label[%0d]", n), longint'(s_if.label), vecs[n].exp_label);
        chk($sformatf("small_score[%0d]", n), longint'(s_if.score), vecs[n].exp_score);
    endtask

    // Reference: plain integer evaluation of the network on the default config
    task automatic ref_model(output int lbl, output longint sc);
        longint hv[BN_HID];
        longint a, best;
        best = 0;
        lbl = 0;
        for (int j = 0; j < BN_HID; j++) begin
            a = longint'(rbh[j]) * (2 ** BFRAC);
            for (int i = 0; i < BN_IN; i++) a += longint'(rx[i]) * rwh[j*BN_IN+i];
            if (a < 0) hv[j] = 0;
            else begin
                a = a / (2 ** BFRAC);
                hv[j] = (a > 127) ? 127 : a;
            end
        end
        for (int k = 0; k < BN_OUT; k++) begin
            a = longint'(rbo[k]) * (2 ** BFRAC);
            for (int j = 0; j < BN_HID; j++) a += hv[j] * rwo[k*BN_HID+j];
            if (k == 0 || a > best) begin
                best = a;
                lbl = k;
            end
        end
        sc = best;
    endtask

    function automatic int rnd(input int r);
        return int'($urandom_range(2 * r, 0)) - r;
    endfunction

    initial begin
        int lat, nd, el, got_label, got_score, r;
        longint es;

        vecs[0] = '{p2(3, -2),   p4(1, 2, 2, -1),       p2(1, 0), p4(1, 1, 0, 2), p2(0, -10),   0, 8};
        vecs[1] = '{p2(3, -2),   p4(1, 2, 2, -1),       p2(1, 0), p4(1, 1, 0, 2), p2(0, -8),    0, 8};
        vecs[2] = '{p2(3, -2),   p4(1, 2, 2, -1),       p2(1, 0), p4(1, 1, 0, 2), p2(0, -7),    1, 9};
        vecs[3] = '{p2(127, 127), p4(127, 127, 127, 127), p2(0, 0), p4(1, 0, 0, 2), p2(0, 0),   1, 254};
        vecs[4] = '{p2(127, 127), p4(-1, -1, -1, -1),   p2(0, 0), p4(1, 0, 0, 2), p2(3, -5),    0, 3};
        vecs[5] = '{p2(0, 0),    p4(0, 0, 0, 0),        p2(5, 6), p4(1, 0, 0, 1), p2(-20, -30), 0, -15};
        vecs[6] = '{p2(0, 0),    p4(0, 0, 0, 0),        p2(5, 6), p4(1, 0, 0, 1), p2(-30, -20), 1, -14};

        s_if.start = 1'b0; b_if.start = 1'b0;
        s_x = '0; s_wh = '0; s_bh = '0; s_wo = '0; s_bo = '0;
        b_x = '0; b_wh = '0; b_bh = '0; b_wo = '0; b_bo = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_s", longint'(s_if.busy), 0);
        chk("reset_done_s", longint'(s_if.done), 0);
        chk("reset_label_s", longint'(s_if.label), 0);
        chk("reset_score_s", longint'(s_if.score), 0);
        chk("reset_busy_b", longint'(b_if.busy), 0);
        chk("reset_label_b", longint'(b_if.label), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table vectors, issued back-to-back (start in the cycle after done)
        for (int n = 0; n < 7; n++) run_small(n);

        // Reset in the middle of an inference
        s_x = vecs[0].x; s_wh = vecs[0].wh; s_bh = vecs[0].bh; s_wo = vecs[0].wo; s_bo = vecs[0].bo;
        s_if.start = 1'b1;
        @(posedge clk); #1;
        s_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_busy", longint'(s_if.busy), 0);
        chk("midrst_done", longint'(s_if.done), 0);
        chk("midrst_label", longint'(s_if.label), 0);
        chk("midrst_score", longint'(s_if.score), 0);
        nd = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (s_if.done) nd++;
        end
        chk("midrst_no_done", nd, 0);
        run_small(0);

        // Start held during busy and input change after accept
        s_x = vecs[2].x; s_wh = vecs[2].wh; s_bh = vecs[2].bh; s_wo = vecs[2].wo; s_bo = vecs[2].bo;
        s_if.start = 1'b1;
        @(posedge clk); #1;
        s_x = p2(100, -50);
        repeat (3) @(posedge clk);
        #1;
        s_if.start = 1'b0;
        nd = 0; got_label = -1; got_score = -1;
        repeat (40) begin
            @(posedge clk); #1;
            if (s_if.done) begin
                nd++;
                got_label = int'(s_if.label);
                got_score = int'(s_if.score);
            end
        end
        chk("held_start_one_done", nd, 1);
        chk("captured_label", got_label, 1);
        chk("captured_score", got_score, 9);

        // Default configuration against the reference model
        for (int v = 0; v < 50; v++) begin
            r = (v % 3 == 0) ? 127 : ((v % 3 == 1) ? 31 : 7);
            for (int i = 0; i < BN_IN; i++) begin
                rx[i] = rnd(r);
                b_x[i*8 +: 8] = 8'(rx[i]);
            end
            for (int n = 0; n < BN_HID*BN_IN; n++) begin
                rwh[n] = rnd(r);
                b_wh[n*8 +: 8] = 8'(rwh[n]);
            end
            for (int n = 0; n < BN_HID; n++) begin
                rbh[n] = rnd(r);
                b_bh[n*8 +: 8] = 8'(rbh[n]);
            end
            for (int n = 0; n < BN_OUT*BN_HID; n++) begin
                rwo[n] = rnd(r);
                b_wo[n*8 +: 8] = 8'(rwo[n]);
            end
            for (int n = 0; n < BN_OUT; n++) begin
                rbo[n] = rnd(r);
                b_bo[n*8 +: 8] = 8'(rbo[n]);
            end
            ref_model(el, es);
            run_and_wait(1'b1, 1600, lat);
            chk($sformatf("big_latency[%0d]", v), lat, 1501);
            chk($sformatf("big_label[%0d]", v), longint'(b_if.label), el);
            chk($sformatf("big_score[%0d]", v), longint'(b_if.score), es);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
